// File: rtl/fib_sched_pkg.sv
// fib_sched_pkg: shared state enum and core widths for fib_scheduler
package fib_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fib_sched_state_t;
  localparam int FIB_N_W = 5;
  localparam int FIB_RES_W = 128;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant starting at ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);
  logic found;
  int idx;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fib_scheduler.sv
// fib_scheduler: round-robin sharing of one fibonacci core among NUM_REQ requesters, optional result cache via FIB_SCHED_CACHE_EN
module fib_scheduler
  import fib_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int N_W = FIB_N_W,
  parameter int RES_W = FIB_RES_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*N_W-1:0] req_n,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [RES_W-1:0]       resp_result,
  output logic                   busy,
  output logic                   core_start,
  output logic [N_W-1:0]         core_n,
  input  logic                   core_finish,
  input  logic [RES_W-1:0]       core_result
);
  localparam int PW = $clog2(NUM_REQ);
  fib_sched_state_t state, state_nx;
  logic [PW-1:0] ptr, own, gnt_idx;
  logic [N_W-1:0] n_reg, sel_n;
  logic [RES_W-1:0] res_reg, hit_res;
  logic [NUM_REQ-1:0] gnt;
  logic accept, hit, capture;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .en(state == IDLE && !rst),
    .gnt(gnt)
  );
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gnt_idx = PW'(i);
  end
  assign accept = |gnt;
  assign sel_n = req_n[int'(gnt_idx)*N_W +: N_W];
  assign capture = state == WAIT && core_finish;
`ifdef FIB_SCHED_CACHE_EN
  logic c_valid;
  logic [N_W-1:0] last_n;
  logic [RES_W-1:0] last_res;
  assign hit = c_valid && sel_n == last_n;
  assign hit_res = last_res;
  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid <= 1'b0;
      last_n <= '0;
      last_res <= '0;
    end else if (capture) begin
      c_valid <= 1'b1;
      last_n <= n_reg;
      last_res <= core_result;
    end
  end
`else
  assign hit = 1'b0;
  assign hit_res = '0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (hit ? RESP : ISSUE) : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = core_finish ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      own <= '0;
      n_reg <= '0;
      res_reg <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        own <= gnt_idx;
        n_reg <= sel_n;
        ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
        if (hit) res_reg <= hit_res;
      end
      if (capture) res_reg <= core_result;
    end
  end
  assign req_ready = gnt;
  assign resp_valid = (state == RESP) ? NUM_REQ'(1) << own : '0;
  assign resp_result = res_reg;
  assign busy = state != IDLE;
  assign core_start = state == ISSUE;
  assign core_n = n_reg;
endmodule

// File: tb/tb_fib_scheduler.sv
// tb_fib_scheduler: scoreboard bench with core model for fib_scheduler
module tb_fib_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [19:0] req_n = '0;
  logic [3:0] req_ready, resp_valid;
  logic [127:0] resp_result;
  logic busy, core_start;
  logic [4:0] core_n;
  logic core_finish = 1'b0;
  logic [127:0] core_result = '0;
  localparam logic [127:0] JUNK = 128'hBAD0_BAD0;
`ifdef FIB_SCHED_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  fib_scheduler dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_n(req_n),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_result(resp_result),
    .busy(busy),
    .core_start(core_start),
    .core_n(core_n),
    .core_finish(core_finish),
    .core_result(core_result)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] own;
    logic [127:0] res;
    bit hit;
    int acc;
  } exp_t;
  exp_t q[$];
  int glog[$];
  int checks = 0, errors = 0, cyc = 0, starts = 0;
  int acc_cyc = 0, fin_cyc = 0, cnt = 0;
  logic [4:0] acc_n = '0, cur_n = '0, cache_n = '0;
  bit cache_v = 1'b0, early = 1'b0;
  logic [3:0] want = '0, drop = '0;
  logic [4:0] want_n[4];
  logic [127:0] want_res[4];
  int rerq[4];
  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic logic [127:0] fib(logic [4:0] n);
    logic [127:0] a = 0, b = 1, t;
    for (int k = 0; k < int'(n); k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rst) begin
      core_finish = 1'b0;
      core_result = JUNK;
      cnt = 0;
      req_valid = '0;
      drop = '0;
      want = '0;
      cache_v = 1'b0;
    end else begin
      if (|resp_valid) begin
        if (q.size() == 0) begin
          check("resp_unexpected", resp_valid, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("resp_owner", resp_valid, e.own);
          check("resp_result", resp_result, e.res);
          check("resp_cycle", cyc, e.hit ? e.acc + 1 : fin_cyc + 1);
          check("resp_busy", busy, 1);
        end
        for (int i = 0; i < 4; i++)
          if (resp_valid[i] && rerq[i] > 0) begin
            want[i] = 1'b1;
            rerq[i]--;
          end
      end
      core_finish = 1'b0;
      core_result = JUNK;
      if (core_start) begin
        starts++;
        check("start_cycle", cyc, acc_cyc + 1);
        check("start_n", core_n, acc_n);
        cur_n = core_n;
        cnt = early ? 5 : int'(core_n) + 3;
        if (early) begin
          core_finish = 1'b1;
          fin_cyc = cyc;
          early = 1'b0;
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_finish = 1'b1;
          core_result = fib(cur_n);
          fin_cyc = cyc;
        end
      end
      for (int i = 0; i < 4; i++)
        if (drop[i]) begin
          req_valid[i] = 1'b0;
          drop[i] = 1'b0;
        end
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && want[i]) begin
          req_valid[i] = 1'b1;
          req_n[i*5 +: 5] = want_n[i];
          want[i] = 1'b0;
        end
      #1;
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          e.own = 4'(1 << i);
          e.res = want_res[i];
          e.hit = CACHE && cache_v && want_n[i] == cache_n;
          e.acc = cyc;
          if (!e.hit) begin
            cache_v = 1'b1;
            cache_n = want_n[i];
          end
          q.push_back(e);
          glog.push_back(i);
          acc_cyc = cyc;
          acc_n = want_n[i];
          drop[i] = 1'b1;
          check("accept_busy", busy, 0);
        end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic post(int i, logic [4:0] n, logic [127:0] r);
    want_n[i] = n;
    want_res[i] = r;
    want[i] = 1'b1;
  endtask
  task automatic settle();
    int b = 0;
    tick();
    while ((q.size() != 0 || want != 0 || req_valid != 0 || drop != 0) && b < 600) begin
      tick();
      b++;
    end
    if (b >= 600) check("settle_timeout", b, 0);
    tick();
  endtask
  task automatic outs_zero(string nm);
    check({nm, "_ready"}, req_ready, 0);
    check({nm, "_resp_valid"}, resp_valid, 0);
    check({nm, "_resp_result"}, resp_result, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_start"}, core_start, 0);
    check({nm, "_core_n"}, core_n, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    for (int i = 0; i < 4; i++) rerq[i] = 0;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    int s0, b;
    for (int i = 0; i < 4; i++) begin
      rerq[i] = 0;
      want_n[i] = '0;
      want_res[i] = '0;
    end
    repeat (2) tick();
    outs_zero("in_reset");
    rst = 1'b0;
    tick();
    outs_zero("after_reset");
    post(1, 10, 55);
    settle();
    check("ptr_after_single", dut.ptr, 2);
    do_reset();
    outs_zero("reset2");
    glog.delete();
    post(0, 3, 2);
    post(1, 4, 3);
    post(2, 5, 5);
    post(3, 6, 8);
    settle();
    check("contention_count", glog.size(), 4);
    for (int i = 0; i < glog.size(); i++) check("contention_order", glog[i], i);
    check("ptr_after_contention", dut.ptr, 0);
    glog.delete();
    rerq[0] = 2;
    rerq[2] = 1;
    post(0, 8, 21);
    post(2, 9, 34);
    settle();
    check("fair_count", glog.size(), 5);
    for (int i = 0; i < glog.size(); i++) check("fair_order", glog[i], (i % 2) * 2);
    early = 1'b1;
    post(3, 12, 144);
    settle();
    s0 = starts;
    post(1, 15, 610);
    b = 0;
    while (starts == s0 && b < 100) begin
      tick();
      b++;
    end
    check("midwait_start_seen", starts, s0 + 1);
    tick();
    do_reset();
    outs_zero("midwait_reset");
    repeat (30) tick();
    check("midwait_no_resp_pending", q.size(), 0);
    post(1, 7, 13);
    settle();
    post(1, 20, 6765);
    settle();
    s0 = starts;
    post(1, 20, 6765);
    settle();
    check("cache_starts", starts - s0, CACHE ? 0 : 1);
    post(2, 21, 10946);
    settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fib_scheduler.md
# fib_scheduler

Shares one `fibonacci` core among `NUM_REQ` requesters. Each requester submits a 5-bit N with a valid/ready handshake. A round-robin arbiter grants one request at a time, and the block sequences the core: it pulses start, holds N, waits for finish and captures the result. The 128-bit result returns on a shared response bus, tagged with a one-hot requester strobe. The block sits directly above the core; the core shares its clock and reset.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `N_W`, default 5: width of N; it matches the core.
- `RES_W`, default 128: width of the result; it matches the core.
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, NUM_REQ: per-requester request pending.
- `req_n`, input, NUM_REQ*N_W: per-requester N; slice i is `[i*N_W +: N_W]`.
- `req_ready`, output, NUM_REQ: one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `resp_valid`, output, NUM_REQ: one-hot, one-cycle strobe to the requester that owns `resp_result`.
- `resp_result`, output, RES_W: result; it holds its value until the next response.
- `busy`, output, 1: high whenever the FSM is not IDLE.
- `core_start`, output, 1: one-cycle start pulse to the core.
- `core_n`, output, N_W: N to the core; it is stable from ISSUE through WAIT.
- `core_finish`, input, 1: core done.
- `core_result`, input, RES_W: core result; it is valid while `core_finish` is high.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - The arbiter picks the first `req_valid` bit at or after priority pointer `ptr`, wrapping modulo NUM_REQ.
  - `req_ready` is asserted only for that requester and only in IDLE; otherwise `req_ready` is 0.
  - On acceptance, the block latches `req_n` into `n_reg` and the owner index into `own`, sets `ptr` to own+1 (mod NUM_REQ), and goes to ISSUE.
  - With no `req_valid`, the block stays in IDLE and `ptr` is unchanged.
- **ISSUE**: `core_start`=1 for exactly one cycle, with `core_n`=`n_reg`; the next state is WAIT.
- **WAIT**
  - `core_finish` is sampled from the cycle after the start pulse onward; finish in the ISSUE cycle is ignored.
  - On the first cycle with `core_finish`=1, the block captures `core_result` into `res_reg` and goes to RESP.
  - There is no timeout.
- **RESP**: `resp_valid[own]`=1 for one cycle and `resp_result`=`res_reg`; the next state is IDLE.
- Requesters hold `req_valid` and `req_n` until accepted. A `req_valid` drop before acceptance is legal; the request is simply not granted.
- Requests that arrive while busy are not accepted; they wait in their requesters.
- `req_n` outside acceptance is don't-care. Every N from 0..31 is passed through unchanged.

## Timing
- All outputs are 0 in and after reset: `req_ready`, `resp_valid`, `resp_result`, `busy`, `core_start` and `core_n`.
- Reset sets `ptr`=0, state=IDLE and clears `own`, `n_reg` and `res_reg`.
- Reset mid-operation aborts the job with no response; the core is reset by the same `rst`.
- Cycle numbering, with acceptance at cycle T and `core_finish` first seen high at cycle F (F ≥ T+2):
  - ISSUE with `core_start`=1 at T+1.
  - WAIT from T+2.
  - RESP with `resp_valid` at F+1.
  - IDLE at F+2, which is the earliest next acceptance.
- With a cache hit (see Configuration), `resp_valid` is at T+1 and IDLE is at T+2; the core is untouched.
- `busy` is high from T+1 through the RESP cycle inclusive.
- Multiple simultaneous `req_valid` bits are served in round-robin order starting at `ptr`. No requester waits more than NUM_REQ-1 jobs.

## Configuration
- `FIB_SCHED_CACHE_EN` defined:
  - A one-entry cache holds a valid bit, `last_n` and `last_res`. It is written on every WAIT capture and its valid bit is cleared by reset.
  - On acceptance in IDLE, if the cache is valid and `req_n` equals `last_n`, the FSM goes directly to RESP with `res_reg`=`last_res`. There is no ISSUE or WAIT.
- `FIB_SCHED_CACHE_EN` undefined: no cache logic exists, and every request goes through ISSUE and WAIT.

## Structure
- Package `fib_sched_pkg`: state enum `fib_sched_state_t` (IDLE, ISSUE, WAIT, RESP), constant `FIB_N_W`=5 and constant `FIB_RES_W`=128.
- Sub-module `rr_arbiter`, parameterised on NUM_REQ:
  - Inputs: `req`, `ptr`, `en`.
  - Output: one-hot `gnt`.
  - Purely combinational; the top level owns the `ptr` register.
- The top level contains the FSM, the job registers, the optional cache and the core-interface drivers.
- The core is instantiated by the parent, not inside this block.

## Test plan
- The bench core model returns fib(N), with fib(0)=0 and fib(1)=1, and asserts `core_finish` N+3 cycles after start.
- Single request: requester 1 sends N=10.
  - Expect `core_start` at T+1 with `core_n`=10.
  - Expect `resp_valid`=0b0010 and `resp_result`=55 at F+1.
- Contention: all four requesters are valid at once with N=3, 4, 5, 6 and `ptr`=0.
  - Grants go 0, 1, 2, 3, with results 2, 3, 5, 8 in that order.
  - After the sequence, `ptr`=0.
- Fairness: requester 0 re-requests immediately after each response while requester 2 is also valid.
  - Grants alternate 0, 2, 0, 2, and requester 2 is never starved.
- Early finish: the core model asserts `core_finish` in the ISSUE cycle and again 5 cycles later.
  - The first assertion is ignored; the capture happens on the second.
- Reset mid-WAIT: `rst` is asserted for one cycle during WAIT.
  - No `resp_valid` is ever issued for that job; all outputs are 0 the next cycle.
  - A new request with N=7 then returns 13.
- Cache (`FIB_SCHED_CACHE_EN`): N=20 is run twice.
  - The second run gives `resp_valid` at T+1 with result 6765 and no `core_start`.
  - A following N=21 returns 10946 through the core.
  - Without the macro, the second N=20 run takes the full core path.
